// File: rtl/hash_ptr_table_if.sv
`default_nettype none
// ============================================================================
// Module      : hash_ptr_table_if
// Description : Request/response handshake bundle between the hash stage,
//               the pointer table and the matcher stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface hash_ptr_table_if #(
    parameter int HASH_W = 12,
    parameter int POS_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [HASH_W-1:0] req_hash;
    logic [POS_W-1:0]  req_pos;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [POS_W-1:0]  rsp_ptr;
    logic [POS_W-1:0]  rsp_offset;

    // Upstream side: issues lookups, consumes responses
    modport master (
        output req_valid, req_hash, req_pos, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_ptr, rsp_offset
    );

    // Table side
    modport slave (
        input  req_valid, req_hash, req_pos, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_ptr, rsp_offset
    );
endinterface
`default_nettype wire

// File: rtl/hash_ptr_table.sv
`default_nettype none
// ============================================================================
// Module      : hash_ptr_table
// Description : LZRW1 hash pointer table. Returns the byte position last
//               stored under a hash index, overwrites it with the current
//               position and flags the old pointer as a match candidate.
//               Optional hit/miss statistics: define PTR_TABLE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_ptr_table #(
    parameter int HASH_W     = 12,
    parameter int POS_W      = 16,
    parameter int MAX_OFFSET = 4095
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         flush,
    output logic              busy,
    hash_ptr_table_if.slave   bus
`ifdef PTR_TABLE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int               DEPTH   = 1 << HASH_W;
    localparam logic [POS_W-1:0] MAX_OFF = POS_W'(MAX_OFFSET);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HASH_W-1:0] clr_cnt;
    logic [HASH_W-1:0] clr_cnt_nxt;

    // Entry layout: {vld, ptr}; no per-entry reset, cleared by the sweep
    logic [POS_W:0]    table_mem [DEPTH];

    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic [POS_W-1:0]  rsp_ptr_q;
    logic [POS_W-1:0]  rsp_offset_q;

    logic              accept;
    logic [POS_W:0]    entry;
    logic [POS_W-1:0]  look_ptr;
    logic [POS_W-1:0]  look_off;
    logic              look_hit;

    // Accept only in RUN and when the output register is free or draining;
    // flush deliberately does not gate acceptance.
    assign bus.req_ready = (state == RUN) && (!rsp_valid_q || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // The table is read combinationally in the accept cycle and written on
    // the same edge that registers the response, so a back-to-back request
    // to the same hash reads the freshly written entry: no stale read.
    assign entry    = table_mem[bus.req_hash];
    assign look_ptr = entry[POS_W] ? entry[POS_W-1:0] : '0;
    assign look_off = bus.req_pos - look_ptr;
    assign look_hit = entry[POS_W] && (look_off != '0) && (look_off <= MAX_OFF);

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_ptr    = rsp_ptr_q;
    assign bus.rsp_offset = rsp_offset_q;

    // State register and clear-sweep counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state logic: flush always (re)starts a full sweep from entry 0
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (flush) begin
                    clr_cnt_nxt = '0;
                end else if (clr_cnt == {HASH_W{1'b1}}) begin
                    state_nxt   = RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Single table write port: sweep writes in CLEAR, update on accept in RUN
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            table_mem[clr_cnt] <= '0;
        end else if (accept) begin
            table_mem[bus.req_hash] <= {1'b1, bus.req_pos};
        end
    end

    // Response register: load on accept, hold while stalled, drop on consume
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_ptr_q    <= '0;
            rsp_offset_q <= '0;
        end else if (accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_hit_q    <= look_hit;
            rsp_ptr_q    <= look_ptr;
            rsp_offset_q <= look_off;
        end else if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

`ifdef PTR_TABLE_STATS_EN
    // Saturating hit/miss counters, counted on each consumed response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (flush) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            if (rsp_hit_q) begin
                if (hit_cnt != 32'hFFFF_FFFF) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hash_ptr_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_ptr_table
// Description : Directed self-checking bench for hash_ptr_table.
//               Statistics checks are built when PTR_TABLE_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_ptr_table;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic busy;
`ifdef PTR_TABLE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int n;
    bit ok;

    hash_ptr_table_if #(.HASH_W(12), .POS_W(16)) bus ();

    hash_ptr_table #(
        .HASH_W     (12),
        .POS_W      (16),
        .MAX_OFFSET (4095)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .busy     (busy),
        .bus      (bus)
`ifdef PTR_TABLE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One accepted request with rsp_ready high; response checked next negedge
    task automatic xfer(input string tag, input logic [11:0] h, input logic [15:0] p,
                        input logic eh, input logic [15:0] ep, input logic [15:0] eo);
        bus.req_valid = 1'b1;
        bus.req_hash  = h;
        bus.req_pos   = p;
        bus.rsp_ready = 1'b1;
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".rsp_hit"}, 32'(bus.rsp_hit), 32'(eh));
        check({tag, ".rsp_ptr"}, 32'(bus.rsp_ptr), 32'(ep));
        check({tag, ".rsp_offset"}, 32'(bus.rsp_offset), 32'(eo));
    endtask

    // Counts negedges spent with busy high (bounded); req_ready must stay low
    task automatic count_busy(output int cnt, output bit rdy_low);
        cnt     = 0;
        rdy_low = 1'b1;
        while (busy === 1'b1 && cnt < 5000) begin
            if (bus.req_ready !== 1'b0) rdy_low = 1'b0;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_hash  = '0;
        bus.req_pos   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.busy", 32'(busy), 32'd1);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.req_ready", 32'(bus.req_ready), 32'd0);
        check("rst.rsp_hit", 32'(bus.rsp_hit), 32'd0);
        check("rst.rsp_ptr", 32'(bus.rsp_ptr), 32'd0);
        check("rst.rsp_offset", 32'(bus.rsp_offset), 32'd0);

        // Initial sweep: exactly 4096 busy cycles
        reset = 1'b1;
        count_busy(n, ok);
        check("sweep.len", 32'(n), 32'd4096);
        check("sweep.ready_low", 32'(ok), 32'd1);
        check("run.busy", 32'(busy), 32'd0);
        check("run.req_ready", 32'(bus.req_ready), 32'd1);

        // Basic miss then hit
        xfer("h123a", 12'h123, 16'd10, 1'b0, 16'd0, 16'd10);
        xfer("h123b", 12'h123, 16'd25, 1'b1, 16'd10, 16'd15);
        // Back-to-back same hash (read-before-write)
        xfer("h7ffa", 12'h7FF, 16'd100, 1'b0, 16'd0, 16'd100);
        xfer("h7ffb", 12'h7FF, 16'd101, 1'b1, 16'd100, 16'd1);
        xfer("h7ffc", 12'h7FF, 16'd102, 1'b1, 16'd101, 16'd1);
        // Window edge: 4096 outside, 4095 inside
        xfer("h010a", 12'h010, 16'd0, 1'b0, 16'd0, 16'd0);
        xfer("h010b", 12'h010, 16'd4096, 1'b0, 16'd0, 16'd4096);
        xfer("h011a", 12'h011, 16'd0, 1'b0, 16'd0, 16'd0);
        xfer("h011b", 12'h011, 16'd4095, 1'b1, 16'd0, 16'd4095);
        // Position wrap
        xfer("h055a", 12'h055, 16'hFFFE, 1'b0, 16'd0, 16'hFFFE);
        xfer("h055b", 12'h055, 16'h0002, 1'b1, 16'hFFFE, 16'd4);
        // Zero offset is not a hit
        xfer("h200a", 12'h200, 16'd50, 1'b0, 16'd0, 16'd50);
        xfer("h200b", 12'h200, 16'd50, 1'b0, 16'd50, 16'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("drain.rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Backpressure: response holds, no new accept
        bus.req_valid = 1'b1;
        bus.req_hash  = 12'h300;
        bus.req_pos   = 16'd500;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("stall.first_valid", 32'(bus.rsp_valid), 32'd1);
        bus.req_hash = 12'h301;
        bus.req_pos  = 16'd600;
        for (int i = 0; i < 5; i++) begin
            check("stall.rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall.rsp_offset", 32'(bus.rsp_offset), 32'd500);
            check("stall.req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end

        // Flush while stalled: response survives, then drains during CLEAR
        flush         = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy", 32'(busy), 32'd1);
        check("flush.rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("flush.rsp_offset", 32'(bus.rsp_offset), 32'd500);
        bus.rsp_ready = 1'b1;
        count_busy(n, ok);
        check("flush.sweep_len", 32'(n), 32'd4096);
        check("flush.ready_low", 32'(ok), 32'd1);
        check("flush.drained", 32'(bus.rsp_valid), 32'd0);
        xfer("post300", 12'h300, 16'd510, 1'b0, 16'd0, 16'd510);
        xfer("post123", 12'h123, 16'd30, 1'b0, 16'd0, 16'd30);

        // Request accepted in the flush cycle completes, then is erased
        bus.req_valid = 1'b1;
        bus.req_hash  = 12'h400;
        bus.req_pos   = 16'd7;
        flush         = 1'b1;
        check("fla.req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        check("fla.rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("fla.rsp_offset", 32'(bus.rsp_offset), 32'd7);
        check("fla.busy", 32'(busy), 32'd1);
        count_busy(n, ok);
        check("fla.sweep_len", 32'(n), 32'd4096);
        xfer("fla.erased", 12'h400, 16'd9, 1'b0, 16'd0, 16'd9);
        bus.req_valid = 1'b0;
        @(negedge clk);

`ifdef PTR_TABLE_STATS_EN
        // Statistics: flush clears, 3 hits and 2 misses counted
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("stats.clr_hit", hit_cnt, 32'd0);
        check("stats.clr_miss", miss_cnt, 32'd0);
        count_busy(n, ok);
        xfer("st1", 12'h500, 16'd1, 1'b0, 16'd0, 16'd1);
        xfer("st2", 12'h500, 16'd2, 1'b1, 16'd1, 16'd1);
        xfer("st3", 12'h500, 16'd3, 1'b1, 16'd2, 16'd1);
        xfer("st4", 12'h500, 16'd4, 1'b1, 16'd3, 16'd1);
        xfer("st5", 12'h501, 16'd5, 1'b0, 16'd0, 16'd5);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("stats.hit_cnt", hit_cnt, 32'd3);
        check("stats.miss_cnt", miss_cnt, 32'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("stats.flush_hit", hit_cnt, 32'd0);
        check("stats.flush_miss", miss_cnt, 32'd0);
        count_busy(n, ok);
`endif

        // Reset mid-operation drops the pending response
        bus.req_valid = 1'b1;
        bus.req_hash  = 12'h600;
        bus.req_pos   = 16'd1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mrst.pre_valid", 32'(bus.rsp_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("mrst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mrst.busy", 32'(busy), 32'd1);
        check("mrst.req_ready", 32'(bus.req_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
